key_event_fifo: RTL

KEY_EVENT_FIFO -- requirements
Module: key_event_fifo

---
 rtl/key_event_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 67 ++++++
 rtl/key_event_fifo.sv | 94 +++++++++
 3 files changed

// File: rtl/key_event_pkg.sv
// Shared definitions for the PS/2 key event FIFO: prefix bytes, decoder
// state encoding and the stored event layout.
package key_event_pkg;

    localparam logic [7:0] PFX_EXT = 8'hE0;   // extended-key prefix
    localparam logic [7:0] PFX_BRK = 8'hF0;   // key-release prefix
    localparam int         EV_W    = 10;      // {break, ext, code}

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GOT_E0   = 2'd1,
        GOT_F0   = 2'd2,
        GOT_E0F0 = 2'd3
    } dec_state_e;

    typedef struct packed {
        logic       brk;
        logic       ext;
        logic [7:0] code;
    } key_ev_t;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with count-based full/empty, sticky overflow
// on dropped writes, and a head output forced to zero while empty.
module sync_fifo #(
    parameter int W     = 10,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CNTW = AW + 1
) (
    input  logic            clk_i,
    input  logic            clr_i,
    input  logic            wr_en_i,
    input  logic [W-1:0]    wr_data_i,
    input  logic            rd_en_i,
    input  logic            ovf_clr_i,
    output logic            rd_valid_o,
    output logic [W-1:0]    rd_data_o,
    output logic [CNTW-1:0] count_o,
    output logic            overflow_o
);

    logic [W-1:0]    mem_q [DEPTH];
    logic [AW-1:0]   rptr_q, wptr_q;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            ovf_q;
    logic            empty, full, do_pop, do_push, drop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CNTW'(DEPTH));
    assign do_pop  = rd_en_i & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = wr_en_i & (~full | do_pop);
    assign drop    = wr_en_i & full & ~do_pop;

    // Occupancy follows the net effect of push and pop.
    always_comb begin
        cnt_d = cnt_q;
        if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
        else if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
    end

    // Pointers, count and sticky overflow; a drop beats a simultaneous clear.
    always_ff @(posedge clk_i or negedge clr_i) begin
        if (!clr_i) begin
            rptr_q <= '0;
            wptr_q <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            cnt_q <= cnt_d;
            if (drop)           ovf_q <= 1'b1;
            else if (ovf_clr_i) ovf_q <= 1'b0;
        end
    end

    // Storage array is not reset; the empty mask hides stale contents.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= wr_data_i;
    end

    assign rd_valid_o = ~empty;
    assign rd_data_o  = empty ? '0 : mem_q[rptr_q];
    assign count_o    = cnt_q;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/key_event_fifo.sv
// PS/2 scan-code prefix decoder feeding a show-ahead key event FIFO.
// Optional macro KEY_EVENT_FIFO_BREAK_EN: when defined, key releases are
// stored; otherwise they are decoded and dropped, and ev_break reads 0.
module key_event_fifo
    import key_event_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          rx_valid,
    input  logic [7:0]    rx_code,
    input  logic          rd_en,
    input  logic          ovf_clr,
    output logic          ev_valid,
    output logic [7:0]    ev_code,
    output logic          ev_break,
    output logic          ev_ext,
    output logic [CW-1:0] count,
    output logic          overflow
);

    localparam int CNTW = $clog2(DEPTH) + 1;

    dec_state_e      state_q;
    logic            is_ext, is_brk, is_data, push;
    key_ev_t         new_ev, head;
    logic [CNTW-1:0] fifo_cnt;

    assign is_ext  = (rx_code == PFX_EXT);
    assign is_brk  = (rx_code == PFX_BRK);
    assign is_data = ~is_ext & ~is_brk;

    assign new_ev.brk  = (state_q == GOT_F0) || (state_q == GOT_E0F0);
    assign new_ev.ext  = (state_q == GOT_E0) || (state_q == GOT_E0F0);
    assign new_ev.code = rx_code;

    // Push is taken straight from the receive strobe so an event is visible
    // the cycle after its final byte arrives.
`ifdef KEY_EVENT_FIFO_BREAK_EN
    assign push = rx_valid & is_data;
`else
    assign push = rx_valid & is_data & ~new_ev.brk;
`endif

    // Prefix decoder: E0 always restarts as a plain extended prefix, F0 adds
    // the release flag, any other byte completes the event.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= IDLE;
        end else if (rx_valid) begin
            if (is_ext) begin
                state_q <= GOT_E0;
            end else if (is_brk) begin
                case (state_q)
                    IDLE:    state_q <= GOT_F0;
                    GOT_E0:  state_q <= GOT_E0F0;
                    default: state_q <= state_q;
                endcase
            end else begin
                state_q <= IDLE;
            end
        end
    end

    sync_fifo #(
        .W     (EV_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i      (clk),
        .clr_i      (clr),
        .wr_en_i    (push),
        .wr_data_i  (new_ev),
        .rd_en_i    (rd_en),
        .ovf_clr_i  (ovf_clr),
        .rd_valid_o (ev_valid),
        .rd_data_o  (head),
        .count_o    (fifo_cnt),
        .overflow_o (overflow)
    );

    assign ev_code = head.code;
    assign ev_ext  = head.ext;
`ifdef KEY_EVENT_FIFO_BREAK_EN
    assign ev_break = head.brk;
`else
    logic unused_brk;
    assign unused_brk = head.brk;
    assign ev_break   = 1'b0;
`endif
    assign count = CW'(fifo_cnt);

endmodule
